// File: rtl/pong_text_pkg.sv
// Shared text constants, line layout indices and writer FSM states for the
// pong text renderer and its line writers.
package pong_text_pkg;

  localparam logic [6:0] BLANK = 7'h20;
  localparam logic [6:0] COLON = 7'h3A;
  localparam logic [6:0] ZERO  = 7'h30;
  localparam logic [6:0] CAP_L = 7'h4C;
  localparam logic [6:0] CAP_R = 7'h52;

  localparam logic [3:0] IDX_L      = 4'd0;
  localparam logic [3:0] IDX_LCOL   = 4'd1;
  localparam logic [3:0] IDX_TENS_L = 4'd2;
  localparam logic [3:0] IDX_ONES_L = 4'd3;
  localparam logic [3:0] IDX_TENS_R = 4'd12;
  localparam logic [3:0] IDX_ONES_R = 4'd13;
  localparam logic [3:0] IDX_RCOL   = 4'd14;
  localparam logic [3:0] IDX_R      = 4'd15;

  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

  // A zero tens digit renders as a blank so scores below ten are right-aligned.
  function automatic logic [6:0] digit_char(input logic [3:0] d, input logic blank_zero);
    logic [6:0] c;
    if (blank_zero && (d == 4'd0)) begin
      c = BLANK;
    end else begin
      c = ZERO + {3'd0, d};
    end
    return c;
  endfunction

endpackage

// File: rtl/bcd_split_seq.sv
// Splits one score (0..99) into tens and ones by repeated subtraction of ten,
// one step per enabled cycle; ready is high once the remainder is below ten.
module bcd_split_seq
  import pong_text_pkg::*;
#(
  parameter int SCORE_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [SCORE_W-1:0] score,
  output logic               ready,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  localparam logic [SCORE_W-1:0] TEN = SCORE_W'(10);

  logic [SCORE_W-1:0] rem_r;
  logic [3:0]         tens_r;

  // Remainder and tens counter: load restarts, each enabled step removes one ten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r  <= '0;
      tens_r <= 4'd0;
    end else if (load) begin
      rem_r  <= score;
      tens_r <= 4'd0;
    end else if (en && !ready) begin
      rem_r  <= rem_r - TEN;
      tens_r <= tens_r + 4'd1;
    end
  end

  // Remainder below ten is the ones digit.
  always_comb begin
    ready = (rem_r < TEN);
    tens  = tens_r;
    ones  = rem_r[3:0];
  end

endmodule

// File: rtl/score_line_writer.sv
// Converts two captured paddle scores to decimal and writes the 16-character
// score line into a buffer that is read through the character-ROM interface.
module score_line_writer
  import pong_text_pkg::*;
#(
  parameter int SCORE_W   = 7,
  parameter int MAX_SCORE = 99,
  parameter int LINE_LEN  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               update,
  input  logic [SCORE_W-1:0] score_l,
  input  logic [SCORE_W-1:0] score_r,
  output logic               busy,
  output logic               done,
  input  logic [7:0]         char_xy,
  output logic [6:0]         char_code
);

  localparam logic [SCORE_W-1:0] MAX_S    = SCORE_W'(MAX_SCORE);
  localparam logic [3:0]         LAST_IDX = 4'(LINE_LEN - 1);

  state_t             state_r, next_state_s;
  logic [3:0]         idx_r;
  logic [6:0]         line_r [LINE_LEN];
  logic [SCORE_W-1:0] clamp_l_s, clamp_r_s;
  logic               load_s, conv_en_s;
  logic               rdy_l_s, rdy_r_s;
  logic [3:0]         tens_l_s, ones_l_s, tens_r_s, ones_r_s;
  logic [6:0]         wr_char_s;
  logic               busy_r, done_r;

  // Clamp scores and decode the acceptance / conversion strobes.
  always_comb begin
    clamp_l_s = (score_l > MAX_S) ? MAX_S : score_l;
    clamp_r_s = (score_r > MAX_S) ? MAX_S : score_r;
    load_s    = (state_r == IDLE) && update;
    conv_en_s = (state_r == CONV);
  end

  bcd_split_seq #(.SCORE_W(SCORE_W)) u_split_l (
    .clk(clk), .rst_n(rst_n), .load(load_s), .en(conv_en_s), .score(clamp_l_s),
    .ready(rdy_l_s), .tens(tens_l_s), .ones(ones_l_s)
  );

  bcd_split_seq #(.SCORE_W(SCORE_W)) u_split_r (
    .clk(clk), .rst_n(rst_n), .load(load_s), .en(conv_en_s), .score(clamp_r_s),
    .ready(rdy_r_s), .tens(tens_r_s), .ones(ones_r_s)
  );

  // Next-state logic; update outside IDLE is dropped.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (update) next_state_s = CONV;
        else        next_state_s = IDLE;
      end
      CONV: begin
        if (rdy_l_s && rdy_r_s) next_state_s = WRITE;
        else                    next_state_s = CONV;
      end
      WRITE: begin
        if (idx_r == LAST_IDX) next_state_s = DONE;
        else                   next_state_s = WRITE;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, write index and status flags; flags trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      idx_r   <= (state_r == WRITE) ? (idx_r + 4'd1) : 4'd0;
      busy_r  <= (state_r == CONV) || (state_r == WRITE);
      done_r  <= (state_r == DONE);
    end
  end

  // Character for the current write index.
  always_comb begin
    wr_char_s = BLANK;
    case (idx_r)
      IDX_L:      wr_char_s = CAP_L;
      IDX_LCOL:   wr_char_s = COLON;
      IDX_TENS_L: wr_char_s = digit_char(tens_l_s, 1'b1);
      IDX_ONES_L: wr_char_s = digit_char(ones_l_s, 1'b0);
      IDX_TENS_R: wr_char_s = digit_char(tens_r_s, 1'b1);
      IDX_ONES_R: wr_char_s = digit_char(ones_r_s, 1'b0);
      IDX_RCOL:   wr_char_s = COLON;
      IDX_R:      wr_char_s = CAP_R;
      default:    wr_char_s = BLANK;
    endcase
  end

  // Line buffer: blanked by reset, one character written per WRITE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_LEN; i++) line_r[i] <= BLANK;
    end else if (state_r == WRITE) begin
      line_r[idx_r] <= wr_char_s;
    end
  end

  // ROM-style read; out-of-range addresses read as blank.
  always_comb begin
    if (char_xy < 8'(LINE_LEN)) char_code = line_r[char_xy[3:0]];
    else                        char_code = BLANK;
    busy = busy_r;
    done = done_r;
  end

endmodule

// File: tb/tb_score_line_writer.sv
// Scoreboard bench: stimulus pushes the expected done cycle and line contents;
// a monitor checks them when done pulses and owns the read address.
module tb_score_line_writer;

  logic       clk = 1'b0;
  logic       rst_n, update;
  logic [6:0] score_l, score_r;
  logic       busy, done;
  logic [7:0] char_xy;
  logic [6:0] char_code;

  typedef struct {
    int              done_cyc;
    logic [15:0][6:0] line;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   sweep_req = 1'b0;
  bit   sweep_full = 1'b0;

  score_line_writer dut (
    .clk(clk), .rst_n(rst_n), .update(update), .score_l(score_l), .score_r(score_r),
    .busy(busy), .done(done), .char_xy(char_xy), .char_code(char_code)
  );

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampv(input int s);
    return (s > 99) ? 99 : s;
  endfunction

  function automatic logic [15:0][6:0] mk_line(input int sl, input int sr);
    logic [15:0][6:0] l;
    int cl, cr;
    cl = clampv(sl);
    cr = clampv(sr);
    for (int i = 0; i < 16; i++) l[i] = 7'h20;
    l[0]  = 7'h4C;
    l[1]  = 7'h3A;
    l[2]  = (cl / 10 == 0) ? 7'h20 : 7'(48 + cl / 10);
    l[3]  = 7'(48 + cl % 10);
    l[12] = (cr / 10 == 0) ? 7'h20 : 7'(48 + cr / 10);
    l[13] = 7'(48 + cr % 10);
    l[14] = 7'h3A;
    l[15] = 7'h52;
    return l;
  endfunction

  // Issue an update at the next negedge; it is sampled at edge k = cyc + 1.
  task automatic issue(input int sl, input int sr, input bit expect_it, output int k);
    exp_t e;
    int t;
    @(negedge clk);
    score_l = 7'(sl);
    score_r = 7'(sr);
    update  = 1'b1;
    k = cyc + 1;
    if (expect_it) begin
      t = (clampv(sl) / 10 > clampv(sr) / 10) ? clampv(sl) / 10 : clampv(sr) / 10;
      e.done_cyc = k + t + 18;
      e.line     = mk_line(sl, sr);
      sb.push_back(e);
    end
    @(negedge clk);
    update  = 1'b0;
    score_l = 7'h55;
    score_r = 7'h2A;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic wait_sweep(input bit full);
    int n = 0;
    sweep_full = full;
    sweep_req  = 1'b1;
    while (sweep_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_timeout", int'(sweep_req), 0);
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: compare done timing and line contents, and service blank sweeps.
  initial begin
    exp_t e;
    char_xy = 8'd0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at cyc %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_in_done", int'(busy), 0);
          for (int i = 0; i < 16; i++) begin
            char_xy = 8'(i);
            #1;
            chk($sformatf("line_idx%0d", i), int'(char_code), int'(e.line[i]));
          end
          char_xy = 8'd0;
        end
      end
      if (sweep_req) begin
        for (int i = 0; i < (sweep_full ? 256 : 16); i++) begin
          char_xy = 8'(i);
          #1;
          chk($sformatf("blank_xy%0d", i), int'(char_code), 32'h20);
        end
        char_xy = 8'd0;
        sweep_req = 1'b0;
      end
    end
  end

  initial begin
    int k, k2, dc;
    rst_n = 1'b0;
    update = 1'b0;
    score_l = 7'd0;
    score_r = 7'd0;
    skip(3);
    rst_n = 1'b1;
    skip(2);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    wait_sweep(1'b1);

    // 7 vs 12: done at k+19, busy rises at k+1.
    issue(7, 12, 1'b1, k);
    chk("busy_at_k", int'(busy), 0);
    @(negedge clk);
    chk("busy_at_k1", int'(busy), 1);
    wait_empty();

    issue(99, 0, 1'b1, k);
    wait_empty();

    issue(120, 100, 1'b1, k);
    wait_empty();

    issue(0, 5, 1'b1, k);
    wait_empty();

    // Extra pulses during CONV and WRITE must be ignored.
    dc = done_cnt;
    issue(55, 33, 1'b1, k);
    issue(11, 22, 1'b0, k2);
    skip(9);
    issue(11, 22, 1'b0, k2);
    wait_empty();
    skip(30);
    chk("single_done", done_cnt - dc, 1);

    // Reset while the write index is 8 abandons the line.
    dc = done_cnt;
    issue(45, 67, 1'b0, k);
    while (cyc < k + 15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", int'(busy), 0);
    chk("done_after_rst", int'(done), 0);
    rst_n = 1'b1;
    wait_sweep(1'b0);
    skip(30);
    chk("no_done_after_rst", done_cnt - dc, 0);

    issue(38, 9, 1'b1, k);
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
